// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops, shift-add MUL and
// restoring DIV/MOD over WIDTH iterations, with a start/busy/done handshake.
module ula_multiciclo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ula_operation,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [7:0]       flags
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIM} state_t;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0001, OP_SUB = 4'b0010, OP_MUL = 4'b0011,
        OP_DIV = 4'b0100, OP_MOD = 4'b0101, OP_AND = 4'b0110,
        OP_OR  = 4'b0111, OP_XOR = 4'b1000, OP_NOT = 4'b1001
    } opcode_t;

    state_t               state, state_next;
    logic [3:0]           op_reg;
    logic [WIDTH-1:0]     b_reg;     // multiplicand (MUL) or divisor (DIV/MOD)
    logic [2*WIDTH-1:0]   acc;       // {product hi, multiplier} or {remainder, quotient}
    logic [CNT_W-1:0]     cnt;

    logic                 accept, is_iter;
    logic [WIDTH-1:0]     sc_res;
    logic [7:0]           sc_flags;
    logic [WIDTH:0]       mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0]   acc_next;
    logic                 div_zero;
    logic [WIDTH-1:0]     fin_res;
    logic [7:0]           fin_flags;

    function automatic logic [7:0] mk_flags(input logic [WIDTH-1:0] r,
                                            input logic c, input logic v,
                                            input logic dz, input logic inv);
        return {2'b00, inv, dz, v, r[WIDTH-1], c, (r == '0)};
    endfunction

    assign busy   = (state == CALC);
    assign done   = (state == FIM);
    assign accept = start && (state != CALC);

    // Single-cycle datapath, evaluated directly on the live inputs
    always_comb begin
        logic [WIDTH:0] ext;
        ext      = '0;
        is_iter  = 1'b0;
        sc_res   = '0;
        sc_flags = mk_flags('0, 1'b0, 1'b0, 1'b0, 1'b1);
        case (ula_operation)
            OP_ADD: begin
                ext      = {1'b0, operand1} + {1'b0, operand2};
                sc_res   = ext[WIDTH-1:0];
                sc_flags = mk_flags(sc_res, ext[WIDTH],
                                    (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                                    (sc_res[WIDTH-1] != operand1[WIDTH-1]), 1'b0, 1'b0);
            end
            OP_SUB: begin
                ext      = {1'b0, operand1} - {1'b0, operand2};
                sc_res   = ext[WIDTH-1:0];
                sc_flags = mk_flags(sc_res, ext[WIDTH],
                                    (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                                    (sc_res[WIDTH-1] != operand1[WIDTH-1]), 1'b0, 1'b0);
            end
            OP_MUL, OP_DIV, OP_MOD: is_iter = 1'b1;
            OP_AND: begin
                sc_res   = operand1 & operand2;
                sc_flags = mk_flags(sc_res, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            OP_OR: begin
                sc_res   = operand1 | operand2;
                sc_flags = mk_flags(sc_res, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            OP_XOR: begin
                sc_res   = operand1 ^ operand2;
                sc_flags = mk_flags(sc_res, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            OP_NOT: begin
                sc_res   = ~operand1;
                sc_flags = mk_flags(sc_res, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            default: ;
        endcase
    end

    // One iteration of shift-add / restoring division, plus the final result
    always_comb begin
        div_zero  = (b_reg == '0);
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_reg} : '0);
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, b_reg};
        acc_next  = acc;
        fin_res   = '0;
        fin_flags = '0;
        if (op_reg == OP_MUL) begin
            acc_next  = {mul_sum, acc[WIDTH-1:1]};
            fin_res   = acc_next[WIDTH-1:0];
            fin_flags = mk_flags(fin_res, 1'b0, |acc_next[2*WIDTH-1:WIDTH], 1'b0, 1'b0);
        end else begin
            // Divide-by-zero leaves acc untouched so its low half still holds operand1
            if (!div_zero) begin
                if (!div_diff[WIDTH])
                    acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                else
                    acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
            if (op_reg == OP_DIV)
                fin_res = div_zero ? '1 : acc_next[WIDTH-1:0];
            else
                fin_res = div_zero ? acc_next[WIDTH-1:0] : acc_next[2*WIDTH-1:WIDTH];
            fin_flags = mk_flags(fin_res, 1'b0, 1'b0, div_zero, 1'b0);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE, FIM: begin
                if (start) state_next = is_iter ? CALC : FIM;
                else       state_next = IDLE;
            end
            CALC:    if (cnt == CNT_W'(1)) state_next = FIM;
            default: state_next = IDLE;
        endcase
    end

    // Operand latching, iteration and result/flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg <= '0;
            b_reg  <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            flags  <= '0;
        end else if (accept) begin
            op_reg <= ula_operation;
            if (is_iter) begin
                cnt <= CNT_W'(WIDTH);
                if (ula_operation == OP_MUL) begin
                    b_reg <= operand1;
                    acc   <= {{WIDTH{1'b0}}, operand2};
                end else begin
                    b_reg <= operand2;
                    acc   <= {{WIDTH{1'b0}}, operand1};
                end
            end else begin
                result <= sc_res;
                flags  <= sc_flags;
            end
        end else if (state == CALC) begin
            acc <= acc_next;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                result <= fin_res;
                flags  <= fin_flags;
            end
        end
    end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Directed self-checking bench for ula_multiciclo (WIDTH=8).
module tb_ula_multiciclo;

    localparam logic [3:0] ADD = 4'b0001, SUB = 4'b0010, MUL = 4'b0011,
                           DIV = 4'b0100, MOD = 4'b0101, AND = 4'b0110,
                           BAD = 4'b1111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] ula_operation = '0;
    logic [7:0] operand1 = '0, operand2 = '0;
    logic       busy, done;
    logic [7:0] result, flags;

    int total = 0;
    int bad = 0;

    ula_multiciclo #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ula_operation(ula_operation),
        .operand1(operand1), .operand2(operand2),
        .busy(busy), .done(done), .result(result), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Present a request and let the next rising edge accept it; returns #1 after that edge
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        start = 1'b1; ula_operation = op; operand1 = a; operand2 = b;
        @(posedge clk); #1;
        start = 1'b0; operand1 = 8'hA5; operand2 = 8'h5A;
    endtask

    // Edges from acceptance until done, counting busy cycles seen along the way
    task automatic wait_done(output int lat, output int nbusy);
        lat = 1; nbusy = 0;
        while (!done && lat < 30) begin
            if (busy) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = -1;
    endtask

    initial begin
        int lat, nbusy, ndone;

        // Reset
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_result", result, 8'h00);
        check("rst_flags", flags, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);

        // ADD 200+100
        @(negedge clk);
        issue(ADD, 8'd200, 8'd100);
        wait_done(lat, nbusy);
        check("add_lat", lat, 1);
        check("add_busy", nbusy, 0);
        check("add_result", result, 8'h2C);
        check("add_flags", flags, 8'b0000_0010);

        // SUB 5-6
        @(negedge clk);
        issue(SUB, 8'd5, 8'd6);
        wait_done(lat, nbusy);
        check("sub_lat", lat, 1);
        check("sub_result", result, 8'hFF);
        check("sub_flags", flags, 8'b0000_0110);

        // MUL 20*13 with an AND request during busy cycle 3 that must be dropped
        @(negedge clk);
        issue(MUL, 8'd20, 8'd13);
        lat = 1; nbusy = 0; ndone = 0;
        while (!done && lat < 30) begin
            if (busy) nbusy++;
            if (nbusy == 3 && busy) begin
                start = 1'b1; ula_operation = AND; operand1 = 8'h0F; operand2 = 8'h0F;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check("mul_lat", lat, 9);
        check("mul_busy", nbusy, 8);
        check("mul_result", result, 8'h04);
        check("mul_flags", flags, 8'b0000_1000);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("mul_no_extra_done", ndone, 0);
        check("mul_hold_result", result, 8'h04);

        // DIV 200/7 then back-to-back MOD accepted in the FIM cycle
        @(negedge clk);
        issue(DIV, 8'd200, 8'd7);
        wait_done(lat, nbusy);
        check("div_lat", lat, 9);
        check("div_result", result, 8'h1C);
        check("div_flags", flags, 8'h00);
        issue(MOD, 8'd200, 8'd7);
        check("b2b_busy", busy, 1);
        wait_done(lat, nbusy);
        check("mod_lat", lat, 9);
        check("mod_result", result, 8'h04);
        check("mod_flags", flags, 8'h00);

        // Divide by zero
        @(negedge clk);
        issue(DIV, 8'd9, 8'd0);
        wait_done(lat, nbusy);
        check("div0_lat", lat, 9);
        check("div0_result", result, 8'hFF);
        check("div0_flags", flags, 8'b0001_0100);
        @(negedge clk);
        issue(MOD, 8'd9, 8'd0);
        wait_done(lat, nbusy);
        check("mod0_lat", lat, 9);
        check("mod0_result", result, 8'h09);
        check("mod0_flags", flags, 8'b0001_0000);

        // Invalid opcode
        @(negedge clk);
        issue(BAD, 8'h33, 8'h44);
        wait_done(lat, nbusy);
        check("inv_lat", lat, 1);
        check("inv_result", result, 8'h00);
        check("inv_flags", flags, 8'b0010_0001);

        // MUL 255*255 aborted by reset at busy cycle 4
        @(negedge clk);
        issue(MUL, 8'd255, 8'd255);
        for (int i = 1; i < 4; i++) begin
            @(posedge clk); #1;
        end
        check("abort_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_result", result, 8'h00);
        check("abort_flags", flags, 8'h00);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        check("abort_no_done", ndone, 0);

        // ADD 1+1 after recovery
        @(negedge clk);
        issue(ADD, 8'd1, 8'd1);
        wait_done(lat, nbusy);
        check("post_lat", lat, 1);
        check("post_result", result, 8'h02);
        check("post_flags", flags, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
